sift_desc_tx: RTL
=================

# sift_desc_tx

Descriptor transmitter at the output side of the SIFT descriptor stage. Captures each finished 1024-bit keypoint descriptor, its keypoint coordinate and main orientation on the stage's completion flag. Buffers up to two descriptors. Streams each one out as a frame of 32-bit words over a valid/ready interface toward the host or DMA side, and counts descriptors lost to overflow.

## Interface
Parameters:
- DROP_W, 16, width of the saturating drop counter

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- desc_in  in  1024  descriptor; bits [1023:960] = sub-histogram 1 … [63:0] = sub-histogram 16
- desc_done  in  1  descriptor-complete flag from the descriptor stage; may stay high for several cycles
- kp_addr  in  18  keypoint coordinate, {row[17:8], col[7:0]}, valid with desc_done
- main_dir  in  6  main orientation bin 0..35, valid with desc_done
- tx_data  out  32  stream word
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts word when high together with tx_valid
- tx_sof  out  1  first word of frame (qualified by tx_valid)
- tx_last  out  1  last word of frame (qualified by tx_valid)
- buf_full  out  1  both buffer entries occupied
- drop_cnt  out  DROP_W  descriptors discarded due to full buffer, saturating

## Operation
- Capture: detect the rising edge of desc_done (sampled 1, previous sample 0); ignore the remainder of a long pulse.
- On an edge, write {desc_in, kp_addr, main_dir} into the entry at wr_ptr.
- Accept the capture if occupancy < 2, or if the current frame's final handshake happens on the same edge. That edge frees the read entry first.
- Otherwise discard the capture and increment drop_cnt. Hold drop_cnt at 2^DROP_W−1.
- Buffer: two entries, 1-bit wr_ptr/rd_ptr, 2-bit occupancy; buf_full = (occupancy == 2).
- TX FSM states:
  - IDLE: tx_valid=0. Go to HDR (or BODY when the header is compiled out) when occupancy > 0.
  - HDR: tx_data = {8'hA5, main_dir, kp_addr}, tx_sof=1. Go to BODY on handshake, word counter = 0.
  - BODY: tx_data = desc_in[1023−32·k -: 32] for k = 0..31. tx_last=1 at k=31.
  - At the k=31 handshake: free the entry and advance rd_ptr. Then go to HDR/BODY if another entry is pending, else IDLE.
- Handshake = tx_valid && tx_ready at a posedge. tx_data, tx_sof and tx_last hold stable while tx_valid && !tx_ready.
- tx_valid never drops mid-frame once asserted.
- Word order within the 32-bit word is big-endian: the first histogram byte is in bits [31:24].

## Timing
- Reset values: tx_valid=0, tx_data=0, tx_sof=0, tx_last=0, buf_full=0, drop_cnt=0, FSM=IDLE, pointers and occupancy=0.
- Latency: desc_done edge sampled at posedge N with the block idle and empty → tx_valid=1 and first word on the bus after posedge N+1.
- Throughput: one word per cycle with tx_ready held high.
  - Frame = 33 cycles with header, 32 without.
  - Back-to-back frames with no idle cycle between the tx_last handshake and the next tx_sof.
- Reset asserted mid-frame: the frame is abandoned immediately, with no tx_last. Buffered entries and drop_cnt are cleared.
- desc_done already high when reset releases: not treated as an edge. The edge register resets to 1.

## Configuration
- SIFT_DESC_TX_HDR_EN defined:
  - Each frame begins with the header word; tx_sof is on the header; frame length is 33.
- Not defined:
  - HDR state and the kp_addr/main_dir storage are removed; frame length is 32.
  - tx_sof is on the first descriptor word; kp_addr and main_dir are unused.

## Test plan
- Single descriptor with desc_in[1023:992]=32'h01020304, kp_addr=18'h0A0B, main_dir=17, tx_ready=1 → header 32'hA5440A0B at the cycle after the edge. Then 32 words with the first = 32'h01020304, tx_last on word 31, and tx_valid=0 afterward.
- desc_done held high 4 cycles → exactly one frame, drop_cnt stays 0.
- Three edges 3 cycles apart with tx_ready=0 → buf_full=1 after the second and drop_cnt=1 after the third. Releasing tx_ready yields exactly two frames in capture order.
- tx_ready toggling 1/0 every cycle → tx_data and tx_last stable during stalls; 33 handshakes per frame; no word lost or repeated.
- With occupancy 2, a capture edge on the same posedge as the tx_last handshake → capture accepted, drop_cnt unchanged, three frames total.
- Reset pulsed low during word 10 of a frame → all outputs at their reset values within the reset cycle, no tx_last seen. A new edge after release yields a complete fresh frame.

Source files
------------

// File: rtl/sift_desc_tx.sv
// sift_desc_tx -- descriptor transmitter at the output of the SIFT descriptor stage.
// Captures a finished 1024-bit descriptor on the rising edge of desc_done and
// holds it in a two-entry buffer. Each entry is streamed out as one frame of
// 32-bit words over valid/ready. Captures that arrive while the buffer is full
// are dropped, and drop_cnt counts them until it saturates.
// Build option: define SIFT_DESC_TX_HDR_EN to prefix every frame with a header
// word {8'hA5, main_dir, kp_addr}, giving 33 words per frame. Without it the
// header and its stored fields are left out and a frame is 32 words long.
module sift_desc_tx #(
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1023:0]     desc_in,
  input  logic              desc_done,
  input  logic [17:0]       kp_addr,
  input  logic [5:0]        main_dir,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sof,
  output logic              tx_last,
  output logic              buf_full,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd2;
`ifdef SIFT_DESC_TX_HDR_EN
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_FIRST = ST_HDR;
`else
  localparam logic [1:0] ST_FIRST = ST_BODY;
`endif

  // Two buffer entries. Both are kept in flops because the body word mux
  // reads the whole entry combinationally.
  logic [1023:0] desc_mem [2];
`ifdef SIFT_DESC_TX_HDR_EN
  logic [17:0]   kp_mem   [2];
  logic [5:0]    dir_mem  [2];
`else
  logic          unused_hdr_fields;
  assign unused_hdr_fields = ^{kp_addr, main_dir};
`endif

  logic [1:0]        state_reg, state_next;
  logic [4:0]        word_cnt_reg, word_cnt_next;
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        occ_reg, occ_next;
  logic              done_q_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

  logic cap_edge, hs, last_hs, cap_accept, frame_pending;

  // A capture is an edge of desc_done. The rest of a long pulse is ignored.
  assign cap_edge = desc_done && !done_q_reg;
  assign hs       = tx_valid && tx_ready;
  assign last_hs  = hs && (state_reg == ST_BODY) && (word_cnt_reg == 5'd31);
  // The final handshake of a frame frees its entry on the same edge, so a full
  // buffer can still take a capture that coincides with it.
  assign cap_accept    = cap_edge && ((occ_reg != 2'd2) || last_hs);
  assign frame_pending = (occ_next != 2'd0);

  // Occupancy after this edge: one entry freed by the last handshake, one added by a capture.
  always_comb begin
    occ_next = occ_reg;
    case ({cap_accept, last_hs})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  // Frame sequencer: leave IDLE when data is buffered, step one word per handshake.
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (occ_reg != 2'd0) begin
          state_next    = ST_FIRST;
          word_cnt_next = 5'd0;
        end
      end
`ifdef SIFT_DESC_TX_HDR_EN
      ST_HDR: begin
        if (tx_ready) begin
          state_next    = ST_BODY;
          word_cnt_next = 5'd0;
        end
      end
`endif
      ST_BODY: begin
        if (tx_ready) begin
          if (word_cnt_reg == 5'd31) begin
            // Move straight into the next frame so there is no idle gap between frames.
            state_next    = frame_pending ? ST_FIRST : ST_IDLE;
            word_cnt_next = 5'd0;
          end else begin
            word_cnt_next = word_cnt_reg + 5'd1;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        word_cnt_next = 5'd0;
      end
    endcase
  end

  // Slice the entry being sent into 32 big-endian words. Word 0 is the first histogram.
  logic [1023:0] rd_desc;
  logic [31:0]   body_word [32];
  assign rd_desc = desc_mem[rd_ptr_reg];
  for (genvar gi = 0; gi < 32; gi++) begin : g_body_word
    assign body_word[gi] = rd_desc[1023 - 32*gi -: 32];
  end

  // Output word and frame markers come only from registered state, so they
  // stay stable while the sink stalls.
  always_comb begin
    tx_data = 32'd0;
    tx_sof  = 1'b0;
    tx_last = 1'b0;
    case (state_reg)
`ifdef SIFT_DESC_TX_HDR_EN
      ST_HDR: begin
        tx_data = {8'hA5, dir_mem[rd_ptr_reg], kp_mem[rd_ptr_reg]};
        tx_sof  = 1'b1;
      end
`endif
      ST_BODY: begin
        tx_data = body_word[word_cnt_reg];
        tx_last = (word_cnt_reg == 5'd31);
`ifndef SIFT_DESC_TX_HDR_EN
        tx_sof  = (word_cnt_reg == 5'd0);
`endif
      end
      default: begin
        tx_data = 32'd0;
      end
    endcase
  end

  assign tx_valid = (state_reg != ST_IDLE);
  assign buf_full = (occ_reg == 2'd2);
  assign drop_cnt = drop_cnt_reg;

  // Buffer payload write. It needs no reset because occupancy says which entries are valid.
  always_ff @(posedge clk) begin
    if (cap_accept) begin
      desc_mem[wr_ptr_reg] <= desc_in;
`ifdef SIFT_DESC_TX_HDR_EN
      kp_mem[wr_ptr_reg]   <= kp_addr;
      dir_mem[wr_ptr_reg]  <= main_dir;
`endif
    end
  end

  // Control state. The edge register resets to 1 so a desc_done that is already high at release is not taken as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= 5'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      occ_reg      <= 2'd0;
      done_q_reg   <= 1'b1;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      occ_reg      <= occ_next;
      done_q_reg   <= desc_done;
      if (cap_accept) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (last_hs) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (cap_edge && !cap_accept && (drop_cnt_reg != {DROP_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
      end
    end
  end

endmodule
